// File: rtl/forward_tracker_if.sv
// Forwarding-bus interface: issue/decode inputs toward the tracker, per-stage forward bundles back.
interface forward_tracker_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 64
);
    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic              regwrite;
        logic [DATA_W-1:0] result;
    } forward_data_t;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_wa;
    logic              issue_regwrite;
    logic              issue_is_load;
    logic              issue_is_md;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] exe_result;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] wb_result;
    logic              flush;
    forward_data_t     forwardE;
    forward_data_t     forwardM;
    forward_data_t     forwardW;
    logic              stall;
    logic              md_busy;

    // Tracker side
    modport master (
        input  issue_valid, issue_wa, issue_regwrite, issue_is_load, issue_is_md,
        input  ra1, ra2, exe_result, mem_result, wb_result, flush,
        output forwardE, forwardM, forwardW, stall, md_busy
    );

    // Pipeline / decode side
    modport slave (
        output issue_valid, issue_wa, issue_regwrite, issue_is_load, issue_is_md,
        output ra1, ra2, exe_result, mem_result, wb_result, flush,
        input  forwardE, forwardM, forwardW, stall, md_busy
    );
endinterface

// File: rtl/forward_tracker.sv
// Tracks in-flight destination registers through E/M/W and drives ready-only forwarding plus stall.
module forward_tracker #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    forward_tracker_if.master bus
);
    localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

    // E needs the op class; M/W data is always ready so only the address matters there
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wa;
        logic              regwrite;
        logic              is_load;
        logic              is_md;
    } e_entry_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wa;
        logic              regwrite;
    } mw_entry_t;

    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic              regwrite;
        logic [DATA_W-1:0] result;
    } fwd_t;

    e_entry_t         e_q, e_d;
    mw_entry_t        m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_busy_c;
    logic             load_use_c;
    fwd_t             fwd_e, fwd_m, fwd_w;

    // Hazard detection from current E entry and decode sources
    always_comb begin
        md_busy_c  = e_q.valid & e_q.is_md & (md_cnt_q != '0);
        load_use_c = e_q.valid & e_q.is_load & e_q.regwrite &
                     (((bus.ra1 != '0) & (bus.ra1 == e_q.wa)) |
                      ((bus.ra2 != '0) & (bus.ra2 == e_q.wa)));
    end

    // Pipeline advance: flush beats mul/div hold beats load-use beats normal issue
    always_comb begin
        e_d      = e_q;
        m_d      = '{valid: e_q.valid, wa: e_q.wa, regwrite: e_q.regwrite};
        w_d      = m_q;
        md_cnt_d = md_cnt_q;
        if (bus.flush) begin
            e_d      = '0;
            md_cnt_d = '0;
        end else if (md_busy_c) begin
            m_d      = '0;
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end else if (load_use_c) begin
            e_d = '0;
        end else begin
            e_d      = '0;
            md_cnt_d = '0;
            if (bus.issue_valid) begin
                e_d.valid    = 1'b1;
                e_d.wa       = bus.issue_wa;
                e_d.regwrite = bus.issue_regwrite & (bus.issue_wa != '0);
                e_d.is_load  = bus.issue_is_load;
                e_d.is_md    = bus.issue_is_md;
                if (bus.issue_is_md) begin
                    md_cnt_d = MD_LOAD;
                end
            end
        end
    end

    // Stage registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            md_cnt_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_q      <= w_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Forward bundles carry only ready data; everything zero when not writing
    always_comb begin
        fwd_e = '0;
        fwd_m = '0;
        fwd_w = '0;
        if (e_q.valid & e_q.regwrite & ~e_q.is_load & ~md_busy_c) begin
            fwd_e = '{wa: e_q.wa, regwrite: 1'b1, result: bus.exe_result};
        end
        if (m_q.valid & m_q.regwrite) begin
            fwd_m = '{wa: m_q.wa, regwrite: 1'b1, result: bus.mem_result};
        end
        if (w_q.valid & w_q.regwrite) begin
            fwd_w = '{wa: w_q.wa, regwrite: 1'b1, result: bus.wb_result};
        end
    end

    assign bus.forwardE = fwd_e;
    assign bus.forwardM = fwd_m;
    assign bus.forwardW = fwd_w;
    assign bus.stall    = md_busy_c | load_use_c;
    assign bus.md_busy  = md_busy_c;
endmodule

// File: tb/tb_forward_tracker.sv
// Scoreboard bench for forward_tracker: directed hazard scenarios plus random traffic vs. a pipeline model.
module tb_forward_tracker;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned MD_CYCLES = 4;
    localparam int unsigned FW_W      = ADDR_W + 1 + DATA_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    forward_tracker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    forward_tracker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MD_CYCLES(MD_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference pipeline: index 0 = E, 1 = M, 2 = W
    typedef struct {
        bit v;
        int wa;
        bit rw;
        bit ld;
        bit md;
    } stage_t;

    typedef struct {
        logic [FW_W-1:0] fe;
        logic [FW_W-1:0] fm;
        logic [FW_W-1:0] fw;
        logic            stall;
        logic            busy;
    } exp_t;

    stage_t pipe[3];
    int     md_left = 0;
    exp_t   expq[$];
    int     checks  = 0;
    int     errors  = 0;

    task automatic chk(input string name, input logic [FW_W-1:0] act, input logic [FW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stage_t bubble();
        stage_t s;
        s = '{v: 1'b0, wa: 0, rw: 1'b0, ld: 1'b0, md: 1'b0};
        return s;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        md_left = 0;
    endfunction

    function automatic bit m_busy();
        return pipe[0].v && pipe[0].md && (md_left > 0);
    endfunction

    function automatic bit m_load_use();
        int r1, r2;
        r1 = int'(bus.ra1);
        r2 = int'(bus.ra2);
        return pipe[0].v && pipe[0].ld && pipe[0].rw &&
               ((r1 != 0 && r1 == pipe[0].wa) || (r2 != 0 && r2 == pipe[0].wa));
    endfunction

    function automatic logic [FW_W-1:0] fwd(input bit live, input int wa, input logic [DATA_W-1:0] r);
        return live ? {ADDR_W'(wa), 1'b1, r} : '0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.busy  = m_busy();
        e.stall = e.busy || m_load_use();
        e.fe    = fwd(pipe[0].v && pipe[0].rw && !pipe[0].ld && !e.busy, pipe[0].wa, bus.exe_result);
        e.fm    = fwd(pipe[1].v && pipe[1].rw, pipe[1].wa, bus.mem_result);
        e.fw    = fwd(pipe[2].v && pipe[2].rw, pipe[2].wa, bus.wb_result);
        return e;
    endfunction

    // One clock edge of the reference, using the inputs that were held before it
    function automatic void model_step();
        bit busy, lu;
        if (!reset) begin
            model_clear();
            return;
        end
        busy = m_busy();
        lu   = m_load_use();
        pipe[2] = pipe[1];
        if (bus.flush) begin
            pipe[1] = pipe[0];
            pipe[0] = bubble();
            md_left = 0;
        end else if (busy) begin
            pipe[1] = bubble();
            md_left = md_left - 1;
        end else if (lu) begin
            pipe[1] = pipe[0];
            pipe[0] = bubble();
        end else begin
            pipe[1] = pipe[0];
            if (bus.issue_valid) begin
                pipe[0] = '{v: 1'b1, wa: int'(bus.issue_wa),
                            rw: bus.issue_regwrite && (bus.issue_wa != 0),
                            ld: bus.issue_is_load, md: bus.issue_is_md};
                md_left = bus.issue_is_md ? int'(MD_CYCLES) - 1 : 0;
            end else begin
                pipe[0] = bubble();
                md_left = 0;
            end
        end
    endfunction

    task automatic drive(input bit iv, input int wa, input bit rw, input bit ld, input bit md,
                         input int r1, input int r2, input bit fl);
        @(posedge clk);
        model_step();
        #1;
        bus.issue_valid    = iv;
        bus.issue_wa       = ADDR_W'(wa);
        bus.issue_regwrite = rw;
        bus.issue_is_load  = ld;
        bus.issue_is_md    = md;
        bus.ra1            = ADDR_W'(r1);
        bus.ra2            = ADDR_W'(r2);
        bus.flush          = fl;
        bus.exe_result     = {$urandom, $urandom};
        bus.mem_result     = {$urandom, $urandom};
        bus.wb_result      = {$urandom, $urandom};
        expq.push_back(model_out());
    endtask

    task automatic idle(input int r1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, r1, 0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fwdE"}, bus.forwardE, '0);
        chk({tag, "_fwdM"}, bus.forwardM, '0);
        chk({tag, "_fwdW"}, bus.forwardW, '0);
        chk({tag, "_stall"}, FW_W'(bus.stall), '0);
        chk({tag, "_md_busy"}, FW_W'(bus.md_busy), '0);
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("sb_fwdE", bus.forwardE, e.fe);
            chk("sb_fwdM", bus.forwardM, e.fm);
            chk("sb_fwdW", bus.forwardW, e.fw);
            chk("sb_stall", FW_W'(bus.stall), FW_W'(e.stall));
            chk("sb_md_busy", FW_W'(bus.md_busy), FW_W'(e.busy));
        end
    end

    initial begin
        model_clear();
        bus.issue_valid = 1'b0; bus.issue_wa = '0; bus.issue_regwrite = 1'b0;
        bus.issue_is_load = 1'b0; bus.issue_is_md = 1'b0;
        bus.ra1 = '0; bus.ra2 = '0; bus.flush = 1'b0;
        bus.exe_result = '0; bus.mem_result = '0; bus.wb_result = '0;
        #2;
        chk_all_zero("reset");
        #10 reset = 1'b1;

        // ALU result flows E -> M -> W
        drive(1'b1, 5, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        idle(0); #1 chk("add_fwdE", bus.forwardE, {5'd5, 1'b1, bus.exe_result});
        chk("add_stall", FW_W'(bus.stall), '0);
        idle(0); #1 chk("add_fwdM", bus.forwardM, {5'd5, 1'b1, bus.mem_result});
        idle(0); #1 chk("add_fwdW", bus.forwardW, {5'd5, 1'b1, bus.wb_result});

        // Load-use: one stall cycle, then value from M
        drive(1'b1, 7, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        idle(7); #1 chk("ld_stall1", FW_W'(bus.stall), FW_W'(1));
        chk("ld_fwdE", bus.forwardE, '0);
        idle(7); #1 chk("ld_fwdM", bus.forwardM, {5'd7, 1'b1, bus.mem_result});
        chk("ld_stall2", FW_W'(bus.stall), '0);
        idle(0); idle(0);

        // Multi-cycle divide holds E for MD_CYCLES-1 cycles
        drive(1'b1, 3, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        for (int c = 1; c < int'(MD_CYCLES); c++) begin
            idle(0); #1;
            chk("div_stall", FW_W'(bus.stall), FW_W'(1));
            chk("div_busy", FW_W'(bus.md_busy), FW_W'(1));
            chk("div_fwdE_hidden", bus.forwardE, '0);
            if (c > 1) chk("div_m_bubble", bus.forwardM, '0);
        end
        idle(0); #1;
        chk("div_done_stall", FW_W'(bus.stall), '0);
        chk("div_done_fwdE", bus.forwardE, {5'd3, 1'b1, bus.exe_result});
        chk("div_done_m_bubble", bus.forwardM, '0);
        idle(0); idle(0); idle(0);

        // Flush while md_cnt==2 frees E at once
        drive(1'b1, 4, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        idle(0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1); #1;
        chk("flush_pre_busy", FW_W'(bus.md_busy), FW_W'(1));
        idle(0); #1;
        chk("flush_busy", FW_W'(bus.md_busy), '0);
        chk("flush_stall", FW_W'(bus.stall), '0);
        chk("flush_fwdE", bus.forwardE, '0);
        idle(0); idle(0); idle(0);

        // Writes to x0 never forward
        drive(1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        idle(0); #1 chk("x0_fwdE", bus.forwardE, '0);
        idle(0); #1 chk("x0_fwdM", bus.forwardM, '0);
        idle(0); #1 chk("x0_fwdW", bus.forwardW, '0);

        // Async reset with a full pipe and a divide in E
        drive(1'b1, 1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 2, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 3, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        idle(0); #1;
        chk("pre_rst_busy", FW_W'(bus.md_busy), FW_W'(1));
        #1 reset = 1'b0;
        model_clear();
        expq.delete();
        #1 chk_all_zero("async_rst");
        idle(0); idle(0);
        #1 reset = 1'b1;
        drive(1'b1, 6, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        idle(0); #1 chk("post_rst_fwdE", bus.forwardE, {5'd6, 1'b1, bus.exe_result});

        // Random traffic with small register space to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), $urandom_range(0, 9) < 8,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
        end
        idle(0); idle(0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
